// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: request FIFO and issue sequencer in front of the multicycle FPU.
// Buffers core requests, holds the FPU enable for each operation's window,
// captures the result into a valid/ready response register, and stalls the
// FPU while that register is back-pressured.
// Optional feature macro: FPU_ISSUE_LATCHK_EN adds the sticky lat_err_o
// latency/handshake checker.
module fpu_issue_seq #(
  parameter int C_OP    = 32,
  parameter int C_RM    = 3,
  parameter int C_CMD   = 4,
  parameter int DEPTH   = 2,
  parameter int FPU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [C_OP-1:0]  req_operand_a_i,
  input  logic [C_OP-1:0]  req_operand_b_i,
  input  logic [C_RM-1:0]  req_rm_i,
  input  logic [C_CMD-1:0] req_op_i,
  output logic [C_OP-1:0]  fpu_operand_a_o,
  output logic [C_OP-1:0]  fpu_operand_b_o,
  output logic [C_RM-1:0]  fpu_rm_o,
  output logic [C_CMD-1:0] fpu_op_o,
  output logic             fpu_enable_o,
  output logic             fpu_stall_o,
  input  logic [C_OP-1:0]  fpu_result_i,
  input  logic             fpu_result_valid_i,
  input  logic             fpu_ready_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [C_OP-1:0]  rsp_result_o,
  output logic             busy_o
`ifdef FPU_ISSUE_LATCHK_EN
  ,
  output logic             lat_err_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  logic [C_OP-1:0]  mem_a_q  [DEPTH];
  logic [C_OP-1:0]  mem_b_q  [DEPTH];
  logic [C_RM-1:0]  mem_rm_q [DEPTH];
  logic [C_CMD-1:0] mem_op_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [C_OP-1:0] rsp_result_q, rsp_result_d;

  logic full, push, pop, exec, slot_free, capture, stall;

  // Handshake decode: push/pop, slot availability and FPU stall.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    push      = req_valid_i && !full;
    exec      = (state_q == S_EXEC);
    slot_free = !rsp_valid_q || rsp_ready_i;
    capture   = exec && fpu_result_valid_i && slot_free;
    stall     = exec && fpu_result_valid_i && !slot_free;
    pop       = capture;
  end

  // Next-state for FIFO pointers/count, sequencer state and response register.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // A push in the same cycle counts as non-empty so the enable starts one
    // cycle after acceptance.
    case (state_q)
      S_IDLE:  if ((count_q != '0) || push) state_d = S_EXEC;
      S_EXEC:  if (capture && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = fpu_result_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  // FIFO storage; cleared on reset so the FPU sees zero operands while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_q[i]  <= '0;
        mem_b_q[i]  <= '0;
        mem_rm_q[i] <= '0;
        mem_op_q[i] <= '0;
      end
    end else if (push) begin
      mem_a_q[wr_ptr_q]  <= req_operand_a_i;
      mem_b_q[wr_ptr_q]  <= req_operand_b_i;
      mem_rm_q[wr_ptr_q] <= req_rm_i;
      mem_op_q[wr_ptr_q] <= req_op_i;
    end
  end

  assign req_ready_o     = !full;
  assign fpu_operand_a_o = mem_a_q[rd_ptr_q];
  assign fpu_operand_b_o = mem_b_q[rd_ptr_q];
  assign fpu_rm_o        = mem_rm_q[rd_ptr_q];
  assign fpu_op_o        = mem_op_q[rd_ptr_q];
  assign fpu_enable_o    = exec;
  assign fpu_stall_o     = stall;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_result_o    = rsp_result_q;
  assign busy_o          = (count_q != '0) || exec;

`ifdef FPU_ISSUE_LATCHK_EN
  localparam int LW = $clog2(FPU_LAT + 1);

  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          lat_err_q, lat_err_d;
  logic          counted;

  // Count unstalled enable cycles of the current op; flag a missing result on
  // the expected cycle or a result offered without FPU ready.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    lat_err_d = lat_err_q;
    counted   = exec && !stall;
    if (counted) begin
      if ((lat_cnt_q == LW'(FPU_LAT - 1)) && !fpu_result_valid_i) lat_err_d = 1'b1;
      if (fpu_result_valid_i && !fpu_ready_i) lat_err_d = 1'b1;
      if (capture) lat_cnt_d = '0;
      else if (lat_cnt_q != LW'(FPU_LAT)) lat_cnt_d = lat_cnt_q + LW'(1);
    end else if (!exec) begin
      lat_cnt_d = '0;
    end
  end

  // Checker registers; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q <= '0;
      lat_err_q <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err_o = lat_err_q;
`else
  // FPU ready only feeds the optional checker.
  logic unused_fpu_ready;
  assign unused_fpu_ready = fpu_ready_i | (FPU_LAT < 1);
`endif

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Self-checking bench for fpu_issue_seq with a behavioural multicycle FPU model
// and an in-order expected-result queue.
module tb_fpu_issue_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [3:0]  op;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  req_rm = '0;
  logic [3:0]  req_op = '0;
  logic [31:0] fpu_a, fpu_b;
  logic [2:0]  fpu_rm;
  logic [3:0]  fpu_op;
  logic        fpu_enable, fpu_stall;
  logic [31:0] fpu_result;
  logic        fpu_result_valid;
  logic        fpu_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        busy;
`ifdef FPU_ISSUE_LATCHK_EN
  logic        lat_err;
`endif

  int tests = 0;
  int fails = 0;
  int fpu_lat_m = 2;
  int fcnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] rm, logic [3:0] op);
    if (a == 32'h3F800000 && b == 32'h40000000 && rm == 3'd0 && op == 4'd0) return 32'h40400000;
    return (a + b) ^ {25'd0, rm, op};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a  = $urandom;
    o.b  = $urandom;
    o.rm = 3'($urandom_range(0, 7));
    o.op = 4'($urandom_range(0, 15));
    return o;
  endfunction

  // Multicycle FPU model: result-valid on the fpu_lat_m-th enable cycle,
  // counter frozen by stall, self-clears after an unstalled final cycle.
  assign fpu_result_valid = fpu_enable && (fcnt == fpu_lat_m - 1);
  assign fpu_result       = fpu_fn(fpu_a, fpu_b, fpu_rm, fpu_op);
  assign fpu_ready        = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt <= 0;
    else if (fpu_enable && !fpu_stall) fcnt <= fpu_result_valid ? 0 : fcnt + 1;
  end

  fpu_issue_seq dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_operand_a_i    (req_a),
    .req_operand_b_i    (req_b),
    .req_rm_i           (req_rm),
    .req_op_i           (req_op),
    .fpu_operand_a_o    (fpu_a),
    .fpu_operand_b_o    (fpu_b),
    .fpu_rm_o           (fpu_rm),
    .fpu_op_o           (fpu_op),
    .fpu_enable_o       (fpu_enable),
    .fpu_stall_o        (fpu_stall),
    .fpu_result_i       (fpu_result),
    .fpu_result_valid_i (fpu_result_valid),
    .fpu_ready_i        (fpu_ready),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_result_o       (rsp_result),
    .busy_o             (busy)
`ifdef FPU_ISSUE_LATCHK_EN
    ,
    .lat_err_o          (lat_err)
`endif
  );

  task automatic drive_op(input logic v, input op_t o);
    req_valid = v;
    req_a     = o.a;
    req_b     = o.b;
    req_rm    = o.rm;
    req_op    = o.op;
  endtask

  task automatic do_reset();
    op_t z;
    z = '0;
    drive_op(1'b0, z);
    rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (fpu_enable !== 1'b0) begin fails++; $display("FAIL reset_enable got %b exp 0", fpu_enable); end
    tests++; if (fpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", fpu_stall); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    tests++; if (rsp_result !== 32'h0) begin fails++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    tests++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0) begin fails++; $display("FAIL reset_operands got %h/%h exp 0/0", fpu_a, fpu_b); end
    do_reset();
  endtask

  task automatic test_single();
    op_t o;
    o = '{a: 32'h3F800000, b: 32'h40000000, rm: 3'd0, op: 4'd0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_op(c == 0, o);
      rsp_ready = 1'b1;
      #1;
      if (c == 0) begin
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL single_ready c=%0d got %b exp 1", c, req_ready); end
      end
      if (c == 1) begin
        tests++; if (fpu_a !== o.a || fpu_b !== o.b) begin fails++; $display("FAIL single_operands got %h/%h exp %h/%h", fpu_a, fpu_b, o.a, o.b); end
      end
      tests++; if (fpu_enable !== (c == 1 || c == 2)) begin fails++; $display("FAIL single_enable c=%0d got %b exp %b", c, fpu_enable, (c == 1 || c == 2)); end
      tests++; if (rsp_valid !== (c == 3)) begin fails++; $display("FAIL single_rsp_valid c=%0d got %b exp %b", c, rsp_valid, (c == 3)); end
      if (c == 3) begin
        tests++; if (rsp_result !== 32'h40400000) begin fails++; $display("FAIL single_result got %h exp 40400000", rsp_result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
      end
      tests++; if (fpu_stall !== 1'b0) begin fails++; $display("FAIL single_stall c=%0d got %b exp 0", c, fpu_stall); end
    end
  endtask

  task automatic test_back_to_back();
    op_t o [2];
    logic [31:0] r [2];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      o[i] = rand_op();
      r[i] = fpu_fn(o[i].a, o[i].b, o[i].rm, o[i].op);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive_op(c < 2, o[c < 2 ? c : 1]);
      rsp_ready = 1'b1;
      #1;
      tests++; if (fpu_enable !== (c >= 1 && c <= 4)) begin fails++; $display("FAIL b2b_enable c=%0d got %b exp %b", c, fpu_enable, (c >= 1 && c <= 4)); end
      tests++; if (rsp_valid !== (c == 3 || c == 5)) begin fails++; $display("FAIL b2b_rsp_valid c=%0d got %b exp %b", c, rsp_valid, (c == 3 || c == 5)); end
      if (c == 3 || c == 5) begin
        tests++; if (rsp_result !== r[(c - 3) / 2]) begin fails++; $display("FAIL b2b_result c=%0d got %h exp %h", c, rsp_result, r[(c - 3) / 2]); end
      end
      tests++; if (fpu_stall !== 1'b0) begin fails++; $display("FAIL b2b_stall c=%0d got %b exp 0", c, fpu_stall); end
    end
  endtask

  task automatic test_backpressure();
    op_t o [2];
    logic [31:0] r [2];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      o[i] = rand_op();
      r[i] = fpu_fn(o[i].a, o[i].b, o[i].rm, o[i].op);
    end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      drive_op(c < 2, o[c < 2 ? c : 1]);
      rsp_ready = (c >= 8);
      #1;
      tests++; if (rsp_valid !== (c >= 3 && c <= 9)) begin fails++; $display("FAIL bp_rsp_valid c=%0d got %b exp %b", c, rsp_valid, (c >= 3 && c <= 9)); end
      if (c >= 3 && c <= 9) begin
        tests++; if (rsp_result !== r[c >= 9 ? 1 : 0]) begin fails++; $display("FAIL bp_result c=%0d got %h exp %h", c, rsp_result, r[c >= 9 ? 1 : 0]); end
      end
      tests++; if (fpu_stall !== (c >= 4 && c <= 7)) begin fails++; $display("FAIL bp_stall c=%0d got %b exp %b", c, fpu_stall, (c >= 4 && c <= 7)); end
      if (c >= 4 && c <= 8) begin
        tests++; if (fpu_result_valid !== 1'b1) begin fails++; $display("FAIL bp_result_valid_held c=%0d got %b exp 1", c, fpu_result_valid); end
      end
    end
  endtask

  task automatic test_fifo_full();
    op_t o [3];
    logic [31:0] r [3];
    int idx, got, acc3;
    do_reset();
    idx = 0; got = 0; acc3 = -1;
    for (int i = 0; i < 3; i++) begin
      o[i] = rand_op();
      r[i] = fpu_fn(o[i].a, o[i].b, o[i].rm, o[i].op);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_op(idx < 3, o[idx < 3 ? idx : 2]);
      rsp_ready = 1'b1;
      #1;
      if (c <= 3) begin
        tests++; if (req_ready !== (c != 2)) begin fails++; $display("FAIL full_ready c=%0d got %b exp %b", c, req_ready, (c != 2)); end
      end
      if (rsp_valid && got < 3) begin
        tests++; if (rsp_result !== r[got]) begin fails++; $display("FAIL full_order n=%0d got %h exp %h", got, rsp_result, r[got]); end
        got++;
      end
      if (req_valid && req_ready) begin
        if (idx == 2) acc3 = c;
        idx++;
      end
    end
    tests++; if (acc3 !== 3) begin fails++; $display("FAIL full_third_accept got cycle %0d exp 3", acc3); end
    tests++; if (got !== 3) begin fails++; $display("FAIL full_resp_count got %0d exp 3", got); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    op_t o;
    o = rand_op();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_op(c == 0, o);
      #1;
    end
    tests++; if (fpu_enable !== 1'b1) begin fails++; $display("FAIL arst_pre_enable got %b exp 1", fpu_enable); end
    #2 rst = 1'b1;
    #1;
    tests++; if (fpu_enable !== 1'b0) begin fails++; $display("FAIL arst_enable got %b exp 0", fpu_enable); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy got %b exp 0", busy); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got %b exp 1", req_ready); end
    tests++; if (fpu_a !== 32'h0) begin fails++; $display("FAIL arst_operand got %h exp 0", fpu_a); end
    tests++; if (rsp_valid !== 1'b0 || rsp_result !== 32'h0) begin fails++; $display("FAIL arst_rsp got %b/%h exp 0/0", rsp_valid, rsp_result); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      tests++; if (rsp_valid !== 1'b0 || fpu_enable !== 1'b0) begin fails++; $display("FAIL arst_after c=%0d got valid %b en %b exp 0 0", c, rsp_valid, fpu_enable); end
    end
  endtask

  task automatic test_latency_check();
    op_t o;
    logic [31:0] r;
    o = rand_op();
    r = fpu_fn(o.a, o.b, o.rm, o.op);
    do_reset();
    fpu_lat_m = 3;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive_op(c == 0, o);
      rsp_ready = 1'b1;
      #1;
      tests++; if (fpu_enable !== (c >= 1 && c <= 3)) begin fails++; $display("FAIL lat_enable c=%0d got %b exp %b", c, fpu_enable, (c >= 1 && c <= 3)); end
      tests++; if (rsp_valid !== (c == 4)) begin fails++; $display("FAIL lat_rsp_valid c=%0d got %b exp %b", c, rsp_valid, (c == 4)); end
      if (c == 4) begin
        tests++; if (rsp_result !== r) begin fails++; $display("FAIL lat_result got %h exp %h", rsp_result, r); end
      end
`ifdef FPU_ISSUE_LATCHK_EN
      tests++; if (lat_err !== (c >= 3)) begin fails++; $display("FAIL lat_err c=%0d got %b exp %b", c, lat_err, (c >= 3)); end
`endif
    end
    fpu_lat_m = 2;
    do_reset();
`ifdef FPU_ISSUE_LATCHK_EN
    #1;
    tests++; if (lat_err !== 1'b0) begin fails++; $display("FAIL lat_err_cleared got %b exp 0", lat_err); end
`endif
  endtask

  task automatic test_random();
    op_t q_ops [$];
    logic [31:0] exp_q [$];
    int issued, got, n_ops;
    logic prev_hold;
    logic [31:0] prev_data;
    op_t cur;
    do_reset();
    n_ops = 40; issued = 0; got = 0; prev_hold = 1'b0; prev_data = '0;
    cur = rand_op();
    for (int c = 0; c < 1500 && got < n_ops; c++) begin
      @(negedge clk);
      if (!req_valid || req_ready) cur = rand_op();
      drive_op((issued < n_ops) && ($urandom_range(0, 99) < 70), cur);
      rsp_ready = ($urandom_range(0, 99) < 60);
      #1;
      if (prev_hold) begin
        tests++; if (rsp_valid !== 1'b1 || rsp_result !== prev_data) begin fails++; $display("FAIL rnd_hold c=%0d got %b/%h exp 1/%h", c, rsp_valid, rsp_result, prev_data); end
      end
      tests++; if (fpu_stall !== (fpu_result_valid && rsp_valid && !rsp_ready)) begin fails++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, fpu_stall, (fpu_result_valid && rsp_valid && !rsp_ready)); end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_spurious c=%0d got %h exp none", c, rsp_result); end
        else begin
          if (rsp_result !== exp_q[0]) begin fails++; $display("FAIL rnd_result n=%0d got %h exp %h", got, rsp_result, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(fpu_fn(cur.a, cur.b, cur.rm, cur.op));
        q_ops.push_back(cur);
        issued++;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_result;
    end
    tests++; if (got !== n_ops) begin fails++; $display("FAIL rnd_count got %0d exp %0d", got, n_ops); end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL rnd_leftover got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fifo_full();
    test_async_reset();
    test_latency_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
- Request sequencer that sits directly upstream of the multicycle FPU wrapper and feeds it.
- Buffers operand/rounding-mode/operator requests from the core in a small FIFO.
- Drives the FPU enable for exactly the FPU's multicycle window, then captures the result into a valid/ready response register.
- Uses the FPU stall input to freeze the FPU while the response register is back-pressured.

Parameters:
- C_OP, 32, operand/result width (matches fpu_defs)
- C_RM, 3, rounding-mode width
- C_CMD, 4, operator width
- DEPTH, 2, request FIFO entries (power of 2, >=2)
- FPU_LAT, 2, enable cycles per operation (used only by the optional latency checker)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  FIFO can accept
- req_operand_a_i  in  C_OP  operand A
- req_operand_b_i  in  C_OP  operand B
- req_rm_i  in  C_RM  rounding mode
- req_op_i  in  C_CMD  operator
- fpu_operand_a_o  out  C_OP  to FPU operand A
- fpu_operand_b_o  out  C_OP  to FPU operand B
- fpu_rm_o  out  C_RM  to FPU rounding mode
- fpu_op_o  out  C_CMD  to FPU operator
- fpu_enable_o  out  1  FPU enable
- fpu_stall_o  out  1  FPU stall
- fpu_result_i  in  C_OP  FPU result
- fpu_result_valid_i  in  1  FPU result-valid (final cycle of op)
- fpu_ready_i  in  1  FPU ready
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_result_o  out  C_OP  response data
- busy_o  out  1  FIFO non-empty or op in flight

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, FSM=IDLE; fpu_enable_o=0, fpu_stall_o=0, rsp_valid_o=0, rsp_result_o=0, busy_o=0, req_ready_o=1.
  - FPU operand outputs 0.
  - Reset mid-operation drops the FIFO contents and the in-flight op.
  - The integration drives the FPU's active-low reset from ~rst, so the FPU's internal counter clears simultaneously.
- FIFO:
  - Push on req_valid_i && req_ready_o.
  - req_ready_o = !full, combinational from registered count.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle when full is not permitted: ready is low when full, regardless of pop.
  - Push and pop in the same cycle when non-full keeps count unchanged.
- FPU outputs are the FIFO head fields, combinational; they are held stable throughout EXEC.
- FSM:
  - IDLE -> EXEC when FIFO non-empty; fpu_enable_o=1 from the next cycle.
  - EXEC: fpu_enable_o=1. On a cycle with fpu_result_valid_i=1:
    - If slot_free (rsp_valid_o=0, or rsp_ready_i=1), capture fpu_result_i into rsp_result_o, set rsp_valid_o next cycle, and pop the FIFO head. Then stay in EXEC if another entry remains (back-to-back; enable stays high, FPU counter self-clears), else go to IDLE.
    - Else assert fpu_stall_o=1 combinationally: FPU count frozen, result-valid stays high, no capture, no pop. Retry every cycle.
  - fpu_stall_o is 0 in IDLE and on cycles without fpu_result_valid_i.
- Response register:
  - rsp_valid_o clears on rsp_ready_i unless a capture occurs in the same cycle; capture plus pop in the same cycle keeps it at 1 with new data.
  - Data is stable while valid && !ready.
- Latency:
  - Request accepted at cycle t with an empty, idle unit: enable at t+1..t+2, rsp_valid_o at t+3.
  - Sustained throughput is 1 op per FPU_LAT cycles with rsp_ready_i=1.
- busy_o = (count!=0) | (state==EXEC).
- fpu_ready_i is used only by the optional checker; sequencing keys on fpu_result_valid_i.

Optional Feature:
- Macro: FPU_ISSUE_LATCHK_EN.
- Defined:
  - Adds output lat_err_o (1 bit, reset 0, sticky until rst).
  - Counts enabled, unstalled EXEC cycles per op; sets lat_err_o if fpu_result_valid_i is not seen on count FPU_LAT.
  - Also sets it if fpu_result_valid_i=1 with fpu_ready_i=0 while not stalled.
- Undefined: no port, no counter; behaviour otherwise identical.

Test Plan:
- Single op, rsp_ready_i=1: push A=0x3F800000, B=0x40000000 at cycle 0; FPU model returns 0x40400000 -> enable high cycles 1-2, rsp_valid_o=1 with 0x40400000 at cycle 3 only, busy_o low at cycle 3.
- Back-to-back: push 2 ops in cycles 0-1, rsp_ready_i=1 -> enable continuous cycles 1-4, rsp_valid_o at cycles 3 and 5 with results in order, fpu_stall_o never 1.
- Back-pressure: 2 ops, rsp_ready_i=0 until cycle 8 -> first result held at cycle 3+; fpu_stall_o=1 from cycle 4 until cycle 8 with second op's result-valid held; second result captured at cycle 8, visible cycle 9.
- FIFO full: DEPTH=2, push 3 ops in consecutive cycles -> req_ready_o=0 when count=2, third push waits and is accepted after the first pop; no op lost or duplicated.
- Async reset at cycle 2 of an op -> all outputs at reset values immediately, FIFO empty, no rsp_valid_o afterwards.
- With FPU_ISSUE_LATCHK_EN: FPU model delays result-valid to 3rd enable cycle -> lat_err_o=1 from the cycle after cycle 2 of enable, stays 1; without the macro the bench still completes the op correctly.
